crc_serial_engine: RTL and testbench

- Parametrised serial CRC engine for the USB packet path. One instance covers both CRC5 (token) and CRC16 (data).
- Two modes:
  - Generate: computes the CRC over a variable-length bit stream, then streams the complemented remainder MSB-first under a downstream ready handshake.
  - Check: absorbs data plus received CRC bits and compares the residual against the polynomial's magic residue.
- Sits between the bit-stuffer/unstuffer and the packet FSMs.

---
 rtl/crc_serial_engine.sv | 160 ++++++++++++++++
 tb/tb_crc_serial_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_engine.sv
// Serial CRC engine: generate mode streams the complemented remainder MSB-first, check mode compares the residual.
// Optional parallel remainder port crc_par is enabled by defining CRC_PAR_OUT_EN.
module crc_serial_engine #(
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = 5'b00101,
  parameter logic [CRC_W-1:0] RESIDUE = 5'b01100,
  parameter int               LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             in_ready,
  output logic             crc_out,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic             done,
  output logic             crc_ok,
  input  logic             ack,
  output logic             busy
`ifdef CRC_PAR_OUT_EN
  ,
  output logic [CRC_W-1:0] crc_par
`endif
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CRC_W-1:0] ONES = {CRC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CHECK, S_STREAM, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CRC_W-1:0] lfsr, lfsr_nxt, sreg;
  logic             ok_q;
  logic             fb, data_last, crc_last;

  assign fb        = lfsr[CRC_W-1] ^ s_in;
  assign lfsr_nxt  = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign data_last = (cnt_inc == {1'b0, len_q});
  assign crc_last  = (cnt_inc == CNT_W'(CRC_W));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    crc_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // zero-length request skips DATA on the same edge
        if (start) state_nxt = (len == '0) ? (mode ? S_CHECK : S_STREAM) : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (s_valid && data_last) state_nxt = mode_q ? S_CHECK : S_STREAM;
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (s_valid && crc_last) state_nxt = S_DONE;
      end
      S_STREAM: begin
        crc_valid = 1'b1;
        if (crc_ready && crc_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign crc_out = crc_valid & sreg[CRC_W-1];
  assign crc_ok  = ok_q;

`ifdef CRC_PAR_OUT_EN
  logic [CRC_W-1:0] par_q;
  assign crc_par = par_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      len_q  <= '0;
      cnt    <= '0;
      lfsr   <= ONES;
      sreg   <= '0;
      ok_q   <= 1'b0;
`ifdef CRC_PAR_OUT_EN
      par_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode;
          len_q  <= len;
          lfsr   <= ONES;
          cnt    <= '0;
          if (len == '0 && !mode) begin
            sreg <= ~ONES;
`ifdef CRC_PAR_OUT_EN
            par_q <= ~ONES;
`endif
          end
        end
        S_DATA: if (s_valid) begin
          lfsr <= lfsr_nxt;
          if (data_last) begin
            cnt <= '0;
            if (!mode_q) begin
              sreg <= ~lfsr_nxt;
`ifdef CRC_PAR_OUT_EN
              par_q <= ~lfsr_nxt;
`endif
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_CHECK: if (s_valid) begin
          lfsr <= lfsr_nxt;
          cnt  <= cnt_inc;
          if (crc_last) begin
            ok_q <= (lfsr_nxt == RESIDUE);
`ifdef CRC_PAR_OUT_EN
            par_q <= lfsr_nxt;
`endif
          end
        end
        S_STREAM: if (crc_ready) begin
          sreg <= {sreg[CRC_W-2:0], 1'b0};
          cnt  <= cnt_inc;
        end
        S_DONE: if (ack) begin
          ok_q <= 1'b0;
          lfsr <= ONES;
`ifdef CRC_PAR_OUT_EN
          par_q <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: CRC5 and CRC16 instances checked against a polynomial long-division model.
module tb_crc_serial_engine;

  logic        clk, rst_n;
  logic        start5, start16, mode, s_in, s_valid, crc_ready, ack;
  logic [10:0] len;
  logic        in_ready5, crc_out5, crc_valid5, done5, crc_ok5, busy5;
  logic        in_ready16, crc_out16, crc_valid16, done16, crc_ok16, busy16;
`ifdef CRC_PAR_OUT_EN
  logic [4:0]  crc_par5;
  logic [15:0] crc_par16;
`endif

  int checks = 0;
  int errors = 0;
  logic sel16;

  crc_serial_engine u5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode), .len(len),
    .s_in(s_in), .s_valid(s_valid), .in_ready(in_ready5), .crc_out(crc_out5),
    .crc_valid(crc_valid5), .crc_ready(crc_ready), .done(done5), .crc_ok(crc_ok5),
    .ack(ack), .busy(busy5)
`ifdef CRC_PAR_OUT_EN
    , .crc_par(crc_par5)
`endif
  );

  crc_serial_engine #(.CRC_W(16), .POLY(16'h8005), .RESIDUE(16'h800D), .LEN_W(11)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .len(len),
    .s_in(s_in), .s_valid(s_valid), .in_ready(in_ready16), .crc_out(crc_out16),
    .crc_valid(crc_valid16), .crc_ready(crc_ready), .done(done16), .crc_ok(crc_ok16),
    .ack(ack), .busy(busy16)
`ifdef CRC_PAR_OUT_EN
    , .crc_par(crc_par16)
`endif
  );

  wire        cur_in_ready  = sel16 ? in_ready16  : in_ready5;
  wire        cur_crc_out   = sel16 ? crc_out16   : crc_out5;
  wire        cur_crc_valid = sel16 ? crc_valid16 : crc_valid5;
  wire        cur_done      = sel16 ? done16      : done5;
  wire        cur_crc_ok    = sel16 ? crc_ok16    : crc_ok5;
  wire        cur_busy      = sel16 ? busy16      : busy5;
  wire [31:0] cw            = sel16 ? 32'd16 : 32'd5;
  wire [15:0] cur_poly      = sel16 ? 16'h8005 : 16'h0005;
  wire [15:0] cur_res       = sel16 ? 16'h800D : 16'h000C;
  wire [15:0] cur_mask      = sel16 ? 16'hFFFF : 16'h001F;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of (all-ones * x^n + M(x) * x^w) mod G(x), G = x^w + poly, by long division.
  function automatic logic [15:0] ref_rem(input int w, input logic [15:0] poly, input bit msg[$]);
    bit a[$];
    logic [15:0] r;
    int n;
    n = msg.size();
    a = msg;
    for (int k = 0; k < w; k++) a.push_back(1'b0);
    for (int k = 0; k < w; k++) a[k] = a[k] ^ 1'b1;
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j <= w; j++)
          a[i+j] = a[i+j] ^ ((j == 0) ? 1'b1 : poly[w-j]);
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = a[n+k];
    return r;
  endfunction

  function automatic void rand_bits(int n, ref bit q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(bit'($urandom_range(1)));
  endfunction

  task automatic do_start(input logic m, input int l);
    mode    = m;
    len     = l[10:0];
    start5  = !sel16;
    start16 = sel16;
    @(negedge clk);
    start5  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic feed(input bit b[$], input int vpct, input string tag);
    int i, cyc;
    logic bad;
    i = 0; cyc = 0; bad = 1'b0;
    while (i < b.size() && cyc < 2000) begin
      if (cur_in_ready !== 1'b1) bad = 1'b1;
      s_valid = ($urandom_range(99) < vpct);
      s_in    = s_valid ? b[i] : 1'($urandom_range(1));
      if (s_valid) i++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    chk({tag, "_feed_count"}, i, b.size());
    chk({tag, "_in_ready"}, bad, 1'b0);
  endtask

  task automatic stream_collect(input int rpct, input logic [15:0] exp, input string tag);
    int got, cyc;
    logic [15:0] bits;
    got = 0; cyc = 0; bits = '0;
    chk({tag, "_first_vld"}, cur_crc_valid, 1'b1);
    while (got < cw && cyc < 500) begin
      crc_ready = ($urandom_range(99) < rpct);
      if (cur_crc_valid && crc_ready) begin
        bits[cw-1-got] = cur_crc_out;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    crc_ready = 1'b0;
    chk({tag, "_consumed"}, got, cw);
    chk({tag, "_bits"}, bits, exp);
    chk({tag, "_vld_drop"}, cur_crc_valid, 1'b0);
    chk({tag, "_done"}, cur_done, 1'b1);
    chk({tag, "_ok_gen0"}, cur_crc_ok, 1'b0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "_idle_busy"}, cur_busy, 1'b0);
    chk({tag, "_idle_done"}, cur_done, 1'b0);
    chk({tag, "_idle_ok"}, cur_crc_ok, 1'b0);
  endtask

  task automatic run_check(input bit d[$], input logic [15:0] crc, input int vpct, input string tag);
    bit full[$];
    logic exp_ok;
    full = d;
    for (int k = 15; k >= 0; k--) if (k < int'(cw)) full.push_back(crc[k]);
    exp_ok = ((ref_rem(cw, cur_poly, full) & cur_mask) == cur_res);
    do_start(1'b1, d.size());
    feed(full, vpct, tag);
    chk({tag, "_done"}, cur_done, 1'b1);
    chk({tag, "_crc_ok"}, cur_crc_ok, exp_ok);
    chk({tag, "_no_vld"}, cur_crc_valid, 1'b0);
  endtask

  initial begin
    bit d[$], d2[$];
    logic [15:0] gcrc;
    int idx;

    sel16 = 1'b0; rst_n = 1'b0; start5 = 1'b0; start16 = 1'b0; mode = 1'b0;
    len = '0; s_in = 1'b0; s_valid = 1'b0; crc_ready = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",      {busy16, busy5},           2'b00);
    chk("rst_in_ready",  {in_ready16, in_ready5},   2'b00);
    chk("rst_crc_valid", {crc_valid16, crc_valid5}, 2'b00);
    chk("rst_done",      {done16, done5},           2'b00);
    chk("rst_crc_ok",    {crc_ok16, crc_ok5},       2'b00);
    chk("rst_crc_out",   {crc_out16, crc_out5},     2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // len=0 generate goes straight to STREAM with an all-zero CRC
    do_start(1'b0, 0);
    chk("len0_busy", cur_busy, 1'b1);
    stream_collect(100, 16'h0000, "len0");
    do_ack("len0");

    // single zero bit: remainder 11011, streamed complement 00100
    crc_ready = 1'b1;
    do_start(1'b0, 1);
    d = {1'b0};
    feed(d, 100, "len1");
`ifdef CRC_PAR_OUT_EN
    chk("len1_par", crc_par5, 5'b00100);
`endif
    stream_collect(100, 16'h0004, "len1");
    do_ack("len1");
    chk("len1_model", ~ref_rem(5, 16'h0005, d) & 16'h001F, 16'h0004);

    // 11 random bits with input and output stalls, then loop back in check mode
    rand_bits(11, d);
    gcrc = ~ref_rem(5, 16'h0005, d) & 16'h001F;
    do_start(1'b0, 11);
    feed(d, 50, "r11_gen");
    stream_collect(50, gcrc, "r11_gen");
    do_ack("r11_gen");
    run_check(d, gcrc, 50, "r11_chk");
    do_ack("r11_chk");

    // reset in mid-STREAM after two consumed bits
    rand_bits(3, d);
    do_start(1'b0, 3);
    feed(d, 100, "rst_mid");
    crc_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", cur_busy, 1'b0);
    chk("rst_mid_vld", cur_crc_valid, 1'b0);
    chk("rst_mid_done", cur_done, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", cur_crc_valid, 1'b0);
    crc_ready = 1'b0;
    rand_bits(6, d);
    do_start(1'b0, 6);
    feed(d, 70, "post_rst");
    stream_collect(100, ~ref_rem(5, 16'h0005, d) & 16'h001F, "post_rst");
    do_ack("post_rst");

    // start during DATA and ack during STREAM are ignored
    rand_bits(4, d);
    do_start(1'b0, 4);
    d2 = d[0:1];
    feed(d2, 100, "ign_a");
    mode = 1'b1; len = 11'd7; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0; mode = 1'b0;
    chk("ign_start_data", cur_in_ready, 1'b1);
    d2 = d[2:3];
    feed(d2, 100, "ign_b");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ign_ack_vld", cur_crc_valid, 1'b1);
    chk("ign_ack_done", cur_done, 1'b0);
    stream_collect(60, ~ref_rem(5, 16'h0005, d) & 16'h001F, "ign");
    // ack coincident with start in DONE only returns to IDLE
    start5 = 1'b1; ack = 1'b1; len = 11'd2;
    @(negedge clk);
    start5 = 1'b0; ack = 1'b0;
    chk("ack_start_busy", cur_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("ack_start_stay", cur_busy, 1'b0);
    chk("idle_in_ready", cur_in_ready, 1'b0);

    // CRC16: generate, clean check, corrupted check
    sel16 = 1'b1;
    rand_bits(64, d);
    gcrc = ~ref_rem(16, 16'h8005, d);
    do_start(1'b0, 64);
    feed(d, 80, "c16_gen");
`ifdef CRC_PAR_OUT_EN
    chk("c16_par", crc_par16, gcrc);
`endif
    stream_collect(80, gcrc, "c16_gen");
    do_ack("c16_gen");
    run_check(d, gcrc, 80, "c16_ok");
    chk("c16_ok_is1", cur_crc_ok, 1'b1);
    do_ack("c16_ok");
    d2 = d;
    idx = $urandom_range(63);
    d2[idx] = ~d2[idx];
    run_check(d2, gcrc, 80, "c16_bad");
    chk("c16_bad_is0", cur_crc_ok, 1'b0);
    do_ack("c16_bad");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
